dco_fll_ctrl: RTL and testbench
===============================

DCO_FLL_CTRL -- requirements
Module: dco_fll_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the window length, edge count, target and tolerance.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default 10, giving the width of the DCO control word.
REQ-003 The block SHALL have parameter LOCK_WINDOWS, default 4, giving the consecutive in-tolerance windows required to assert lock.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth on fb_i.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, as ports clk_i and arst_ni.
REQ-006 The block SHALL have these ports, name / direction / width / meaning:
- clk_i  in  1  reference clock; the only clock.
- arst_ni  in  1  asynchronous reset, active low.
- en_i  in  1  loop enable.
- fb_i  in  1  divided DCO feedback, asynchronous to clk_i.
- win_len_i  in  CNT_WIDTH  measurement window in clk_i cycles.
- target_i  in  CNT_WIDTH  expected fb_i rising edges per window.
- tol_i  in  CNT_WIDTH  lock tolerance in edges.
- gain_shift_i  in  4  loop gain; step = err >>> gain_shift_i.
- ctrl_init_i  in  CTRL_WIDTH  control word used while idle.
- ctrl_o  out  CTRL_WIDTH  DCO control word.
- locked_o  out  1  lock indicator.
- meas_o  out  CNT_WIDTH  last window edge count.
- err_o  out  CNT_WIDTH+1  signed target_i minus meas_o.
- meas_valid_o  out  1  one-cycle pulse when meas_o, err_o and ctrl_o update.
- sat_o  out  1  the last update clamped ctrl_o.

Function
REQ-007 fb_i SHALL pass through SYNC_STAGES flops; a rising edge is a synchronised 1 whose previous synchronised value was 0.
REQ-008 The FSM SHALL have three states: IDLE, MEASURE and UPDATE.
REQ-009 In IDLE, ctrl_o SHALL load ctrl_init_i every cycle; locked_o, the lock counter and the window counters SHALL be 0; en_i=1 SHALL move the FSM to MEASURE.
REQ-010 MEASURE SHALL last exactly max(win_len_i,1) cycles and count the rising edges detected in those cycles, saturating at all-ones; it then moves to UPDATE.
REQ-011 UPDATE SHALL last one cycle and then return to MEASURE (while en_i=1), giving a window period of W+1 cycles.
REQ-012 UPDATE SHALL compute err = target - count as a signed CNT_WIDTH+1 value, and step = err >>> gain_shift_i as an arithmetic shift.
REQ-013 If |err| <= tol_i, the window SHALL count as in-tolerance and ctrl_o SHALL be unchanged.
REQ-014 Otherwise ctrl_o SHALL become ctrl_o + step, where a zero step is replaced by sign(err).
REQ-015 The sum SHALL be computed at full width and clamped to [0, 2^CTRL_WIDTH-1].
REQ-016 sat_o SHALL be 1 exactly when clamping occurred, and SHALL hold until the next UPDATE.
REQ-017 meas_o, err_o, ctrl_o and sat_o SHALL update on the edge leaving UPDATE; meas_valid_o SHALL be high for exactly the following cycle.
REQ-018 Each in-tolerance window SHALL increment the lock counter, saturating at LOCK_WINDOWS; locked_o SHALL rise with meas_valid_o when the counter reaches LOCK_WINDOWS.
REQ-019 While unlocked, any out-of-tolerance window SHALL clear the lock counter.
REQ-020 While locked, locked_o SHALL fall only on a window with |err| > 2*tol_i or on the second consecutive out-of-tolerance window.
REQ-021 On falling, locked_o SHALL drop and the lock counter SHALL clear.
REQ-022 win_len_i and target_i SHALL be registered every cycle; a mismatch with the registered copy in MEASURE or UPDATE SHALL abort the window.
REQ-023 An aborted window SHALL produce no meas_valid_o, SHALL clear locked_o and the lock counter on the next edge, SHALL restart MEASURE, and SHALL retain ctrl_o.
REQ-024 en_i=0 in any state SHALL move the FSM to IDLE on the next edge; an edge on the same cycle as window end SHALL be counted.

Reset
REQ-025 While arst_ni=0: FSM=IDLE, ctrl_o=0, locked_o=0, meas_o=0, err_o=0, meas_valid_o=0, sat_o=0, and all counters, synchronisers and configuration registers 0, independent of clk_i.
REQ-026 Reset asserted mid-window SHALL discard the window; after release, ctrl_o SHALL load ctrl_init_i on the first clk_i edge.

Verification
REQ-027 Reset check: arst_ni=0 with en_i=1 and fb_i toggling -> every output 0; release with ctrl_init_i=512 -> ctrl_o=512 after one edge.
REQ-028 Steady lock: ctrl_init_i=512, win_len_i=100, target_i=10, tol_i=0, gain_shift_i=0, fb_i rising every 10 cycles -> meas_o=10, err_o=0, ctrl_o=512 on every window; locked_o rises with the 4th meas_valid_o.
REQ-029 Correction: as REQ-028 but target_i=20 -> err_o=+10 and ctrl_o 512->522; with gain_shift_i=4 -> ctrl_o 512->513 (forced minimum step).
REQ-030 Saturation: ctrl_init_i=1020, err=+10, gain_shift_i=0 -> ctrl_o=1023, sat_o=1; the next in-tolerance window -> sat_o=0.
REQ-031 Hysteresis: locked with tol_i=2; one window with err=+3 keeps locked_o=1; a second consecutive such window drops it; a single window with err=+5 drops it immediately.
REQ-032 Configuration change: target_i changed mid-window while locked -> locked_o=0 next cycle, no meas_valid_o for that window, ctrl_o unchanged; en_i=0 mid-window -> IDLE, ctrl_o=ctrl_init_i.

Source files
------------

// File: rtl/dco_fll_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dco_fll_ctrl_if                                            |
// | Purpose : Signal bundle between a DCO frequency-locked-loop          |
// |           controller and its environment (loop configuration in,    |
// |           DCO control word and measurement status out).              |
// | Ports   : en_i, fb_i, win_len_i, target_i, tol_i, gain_shift_i,      |
// |           ctrl_init_i          -> controller                         |
// |           ctrl_o, locked_o, meas_o, err_o, meas_valid_o, sat_o       |
// |                                <- controller                         |
// |           master : environment side, slave : controller side         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface dco_fll_ctrl_if #(
   parameter int CNT_WIDTH  = 16,
   parameter int CTRL_WIDTH = 10
);
   logic                  en_i;
   logic                  fb_i;
   logic [CNT_WIDTH-1:0]  win_len_i;
   logic [CNT_WIDTH-1:0]  target_i;
   logic [CNT_WIDTH-1:0]  tol_i;
   logic [3:0]            gain_shift_i;
   logic [CTRL_WIDTH-1:0] ctrl_init_i;
   logic [CTRL_WIDTH-1:0] ctrl_o;
   logic                  locked_o;
   logic [CNT_WIDTH-1:0]  meas_o;
   logic [CNT_WIDTH:0]    err_o;
   logic                  meas_valid_o;
   logic                  sat_o;

   modport master (
      output en_i, fb_i, win_len_i, target_i, tol_i, gain_shift_i, ctrl_init_i,
      input  ctrl_o, locked_o, meas_o, err_o, meas_valid_o, sat_o
   );

   modport slave (
      input  en_i, fb_i, win_len_i, target_i, tol_i, gain_shift_i, ctrl_init_i,
      output ctrl_o, locked_o, meas_o, err_o, meas_valid_o, sat_o
   );
endinterface
`default_nettype wire

// File: rtl/dco_fll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dco_fll_ctrl                                               |
// | Purpose : Frequency-locked-loop controller for a DCO. Counts rising  |
// |           edges of the (asynchronous) divided feedback over a        |
// |           window of reference cycles, compares with a target and    |
// |           steps the DCO control word by err >>> gain_shift, with     |
// |           clamping, lock detection and lock hysteresis.             |
// | Ports   : clk_i   reference clock (only clock)                       |
// |           arst_ni asynchronous reset, active low                     |
// |           bus     dco_fll_ctrl_if.slave (config in, status out)      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dco_fll_ctrl #(
   parameter int CNT_WIDTH    = 16,
   parameter int CTRL_WIDTH   = 10,
   parameter int LOCK_WINDOWS = 4,
   parameter int SYNC_STAGES  = 2
) (
   input wire               clk_i,
   input wire               arst_ni,
   dco_fll_ctrl_if.slave    bus
);

   localparam int LCNT_W = $clog2(LOCK_WINDOWS + 1);
   // Sum width holds the control word plus a full-width signed step with
   // headroom, so the clamp can see both underflow and overflow.
   localparam int SUM_W  = ((CTRL_WIDTH > CNT_WIDTH + 1) ? CTRL_WIDTH : CNT_WIDTH + 1) + 2;

   localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
   localparam logic [LCNT_W-1:0]    c_lock_one  = LCNT_W'(1);
   localparam logic [LCNT_W-1:0]    c_lock_full = LCNT_W'(LOCK_WINDOWS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      UPDATE  = 2'd2
   } state_t;

   state_t                  r_state;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    r_fb_prev;
   logic [CNT_WIDTH-1:0]    r_win_len;
   logic [CNT_WIDTH-1:0]    r_target;
   logic [CNT_WIDTH-1:0]    r_win_cnt;
   logic [CNT_WIDTH-1:0]    r_edge_cnt;
   logic [LCNT_W-1:0]       r_lock_cnt;
   logic                    r_miss;
   logic                    r_locked;
   logic [CTRL_WIDTH-1:0]   r_ctrl;
   logic [CNT_WIDTH-1:0]    r_meas;
   logic [CNT_WIDTH:0]      r_err;
   logic                    r_meas_valid;
   logic                    r_sat;

   // Edge detection and configuration tracking
   logic                    w_fb_s;
   logic                    w_rise;
   logic                    w_cfg_change;
   logic [CNT_WIDTH-1:0]    w_win_eff;
   logic                    w_win_last;

   assign w_fb_s       = r_sync[SYNC_STAGES-1];
   assign w_rise       = w_fb_s & ~r_fb_prev;
   assign w_cfg_change = (bus.win_len_i != r_win_len) || (bus.target_i != r_target);
   // A zero window length behaves as a one-cycle window.
   assign w_win_eff    = (r_win_len == '0) ? c_cnt_one : r_win_len;
   assign w_win_last   = (r_win_cnt == (w_win_eff - c_cnt_one));

   // Error, step and clamped control word
   logic signed [CNT_WIDTH:0] w_err;
   logic        [CNT_WIDTH:0] w_abs_err;
   logic                      w_in_tol;
   logic                      w_big_err;
   logic signed [CNT_WIDTH:0] w_shifted;
   logic signed [CNT_WIDTH:0] w_step;
   logic signed [SUM_W-1:0]   w_sum;
   logic                      w_sum_neg;
   logic                      w_sum_high;
   logic [CTRL_WIDTH-1:0]     w_ctrl_next;

   assign w_err     = $signed({1'b0, r_target}) - $signed({1'b0, r_edge_cnt});
   assign w_abs_err = w_err[CNT_WIDTH] ? (-w_err) : w_err;
   assign w_in_tol  = (w_abs_err <= {1'b0, bus.tol_i});
   assign w_big_err = ({1'b0, w_abs_err} > {1'b0, bus.tol_i, 1'b0});
   assign w_shifted = w_err >>> bus.gain_shift_i;
   // A step that shifts down to zero still moves by one LSB toward the
   // target, so large gain shifts cannot stall the loop.
   assign w_step    = (w_shifted != '0) ? w_shifted :
                      (w_err[CNT_WIDTH] ? {(CNT_WIDTH+1){1'b1}}
                                        : {{CNT_WIDTH{1'b0}}, 1'b1});
   assign w_sum     = $signed({{(SUM_W-CTRL_WIDTH){1'b0}}, r_ctrl})
                    + $signed({{(SUM_W-CNT_WIDTH-1){w_step[CNT_WIDTH]}}, w_step});
   assign w_sum_neg  = w_sum[SUM_W-1];
   assign w_sum_high = !w_sum_neg && (|w_sum[SUM_W-2:CTRL_WIDTH]);
   assign w_ctrl_next = w_sum_neg  ? '0 :
                        w_sum_high ? '1 : w_sum[CTRL_WIDTH-1:0];

   // Lock bookkeeping for a completed window
   logic [LCNT_W-1:0] w_lock_cnt_nx;
   logic              w_locked_nx;
   logic              w_miss_nx;

   always_comb begin
      w_lock_cnt_nx = r_lock_cnt;
      w_locked_nx   = r_locked;
      w_miss_nx     = r_miss;
      if (!r_locked) begin
         w_miss_nx = 1'b0;
         if (w_in_tol) begin
            w_lock_cnt_nx = (r_lock_cnt == c_lock_full) ? c_lock_full : (r_lock_cnt + c_lock_one);
            w_locked_nx   = (w_lock_cnt_nx == c_lock_full);
         end else begin
            w_lock_cnt_nx = '0;
         end
      end else if (w_in_tol) begin
         w_miss_nx = 1'b0;
      end else if (w_big_err || r_miss) begin
         // Gross error, or the second miss in a row: lose lock.
         w_locked_nx   = 1'b0;
         w_lock_cnt_nx = '0;
         w_miss_nx     = 1'b0;
      end else begin
         w_miss_nx = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state      <= IDLE;
         r_sync       <= '0;
         r_fb_prev    <= 1'b0;
         r_win_len    <= '0;
         r_target     <= '0;
         r_win_cnt    <= '0;
         r_edge_cnt   <= '0;
         r_lock_cnt   <= '0;
         r_miss       <= 1'b0;
         r_locked     <= 1'b0;
         r_ctrl       <= '0;
         r_meas       <= '0;
         r_err        <= '0;
         r_meas_valid <= 1'b0;
         r_sat        <= 1'b0;
      end else begin
         r_sync[0] <= bus.fb_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_fb_prev    <= w_fb_s;
         r_win_len    <= bus.win_len_i;
         r_target     <= bus.target_i;
         r_meas_valid <= 1'b0;

         if (!bus.en_i || (r_state == IDLE)) begin
            // Idle (or leaving for idle): park the DCO at its initial word.
            r_state    <= bus.en_i ? MEASURE : IDLE;
            r_ctrl     <= bus.ctrl_init_i;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_lock_cnt <= '0;
            r_miss     <= 1'b0;
            r_locked   <= 1'b0;
         end else if (w_cfg_change) begin
            // Window length or target moved under us: the count is
            // meaningless, so restart the window and drop lock.
            r_state    <= MEASURE;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_lock_cnt <= '0;
            r_miss     <= 1'b0;
            r_locked   <= 1'b0;
         end else begin
            case (r_state)
               MEASURE: begin
                  if (w_rise && (r_edge_cnt != '1)) begin
                     r_edge_cnt <= r_edge_cnt + c_cnt_one;
                  end
                  if (w_win_last) begin
                     r_state   <= UPDATE;
                     r_win_cnt <= '0;
                  end else begin
                     r_win_cnt <= r_win_cnt + c_cnt_one;
                  end
               end
               UPDATE: begin
                  r_meas       <= r_edge_cnt;
                  r_err        <= w_err;
                  r_meas_valid <= 1'b1;
                  if (w_in_tol) begin
                     r_sat <= 1'b0;
                  end else begin
                     r_ctrl <= w_ctrl_next;
                     r_sat  <= w_sum_neg | w_sum_high;
                  end
                  r_lock_cnt <= w_lock_cnt_nx;
                  r_locked   <= w_locked_nx;
                  r_miss     <= w_miss_nx;
                  r_edge_cnt <= '0;
                  r_win_cnt  <= '0;
                  r_state    <= MEASURE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.ctrl_o       = r_ctrl;
   assign bus.locked_o     = r_locked;
   assign bus.meas_o       = r_meas;
   assign bus.err_o        = r_err;
   assign bus.meas_valid_o = r_meas_valid;
   assign bus.sat_o        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_dco_fll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dco_fll_ctrl                                            |
// | Purpose : Self-checking bench for dco_fll_ctrl. Feedback edges are   |
// |           emitted as a burst of N pulses at the start of each window |
// |           so the expected count per window is exactly N; a plain     |
// |           integer model predicts err, ctrl, sat and lock.            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_dco_fll_ctrl;
   localparam int CNT_WIDTH    = 16;
   localparam int CTRL_WIDTH   = 10;
   localparam int LOCK_WINDOWS = 4;
   localparam int SYNC_STAGES  = 2;
   localparam int CTRL_MAX     = (1 << CTRL_WIDTH) - 1;

   logic clk     = 1'b0;
   logic arst_ni = 1'b0;

   dco_fll_ctrl_if #(.CNT_WIDTH(CNT_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) bus ();

   dco_fll_ctrl #(
      .CNT_WIDTH   (CNT_WIDTH),
      .CTRL_WIDTH  (CTRL_WIDTH),
      .LOCK_WINDOWS(LOCK_WINDOWS),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_i  (clk),
      .arst_ni(arst_ni),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int m_ctrl, m_err, m_tgt, m_tol, m_gain, m_cnt, m_meas;
   bit m_locked, m_miss, m_sat;
   int g_off;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int floor_div_pow2(input int v, input int g);
      int d;
      d = 1 << g;
      if (v >= 0) return v / d;
      return -((-v + d - 1) / d);
   endfunction

   function automatic logic pulse_at(input int o, input int n, input int sp);
      return (o >= 1) && (((o - 1) % sp) == 0) && (((o - 1) / sp) < n);
   endfunction

   // One completed window with n feedback edges.
   task automatic model_window(input int n);
      int aerr, step, s;
      bit in_tol;
      m_meas = n;
      m_err  = m_tgt - n;
      aerr   = (m_err < 0) ? -m_err : m_err;
      in_tol = (aerr <= m_tol);
      if (in_tol) begin
         m_sat = 1'b0;
      end else begin
         step = floor_div_pow2(m_err, m_gain);
         if (step == 0) step = (m_err > 0) ? 1 : -1;
         s      = m_ctrl + step;
         m_sat  = (s < 0) || (s > CTRL_MAX);
         m_ctrl = (s < 0) ? 0 : ((s > CTRL_MAX) ? CTRL_MAX : s);
      end
      if (!m_locked) begin
         m_miss = 1'b0;
         if (in_tol) begin
            m_cnt = (m_cnt + 1 > LOCK_WINDOWS) ? LOCK_WINDOWS : m_cnt + 1;
            m_locked = (m_cnt == LOCK_WINDOWS);
         end else begin
            m_cnt = 0;
         end
      end else if (in_tol) begin
         m_miss = 1'b0;
      end else if ((aerr > 2 * m_tol) || m_miss) begin
         m_locked = 1'b0;
         m_cnt    = 0;
         m_miss   = 1'b0;
      end else begin
         m_miss = 1'b1;
      end
   endtask

   task automatic model_clear_lock();
      m_cnt    = 0;
      m_locked = 1'b0;
      m_miss   = 1'b0;
   endtask

   // Go idle, apply a configuration, then enable; returns at the negedge of
   // the first MEASURE cycle.
   task automatic start_loop(input int init, input int w, input int tgt, input int tol, input int g);
      bus.en_i = 1'b0;
      bus.fb_i = 1'b0;
      @(negedge clk);
      bus.ctrl_init_i  = CTRL_WIDTH'(init);
      bus.win_len_i    = CNT_WIDTH'(w);
      bus.target_i     = CNT_WIDTH'(tgt);
      bus.tol_i        = CNT_WIDTH'(tol);
      bus.gain_shift_i = 4'(g);
      m_tgt  = tgt;
      m_tol  = tol;
      m_gain = g;
      repeat (2) @(negedge clk);
      chk("idle.ctrl", bus.ctrl_o, init);
      chk("idle.locked", bus.locked_o, 0);
      bus.en_i = 1'b1;
      @(negedge clk);
      m_ctrl = init;
      model_clear_lock();
      g_off = 0;
   endtask

   // Drive a burst of n edges (spacing sp) through one window of length w and
   // check the update that follows.
   task automatic run_window(input int n, input int sp, input int w, input string tag);
      int  o, weff;
      bit  got;
      o    = g_off;
      got  = 1'b0;
      weff = (w == 0) ? 1 : w;
      while (!got && (o <= weff + 20)) begin
         bus.fb_i = pulse_at(o, n, sp);
         @(negedge clk);
         o++;
         got = bus.meas_valid_o;
      end
      bus.fb_i = 1'b0;
      chk({tag, ".period"}, o, weff + 1);
      if (got) begin
         model_window(n);
         chk({tag, ".meas"},   bus.meas_o, m_meas);
         chk({tag, ".err"},    $signed(bus.err_o), m_err);
         chk({tag, ".ctrl"},   bus.ctrl_o, m_ctrl);
         chk({tag, ".sat"},    bus.sat_o, m_sat);
         chk({tag, ".locked"}, bus.locked_o, m_locked);
      end
      @(negedge clk);
      chk({tag, ".pulse"}, bus.meas_valid_o, 0);
      g_off = 1;
   endtask

   // Advance within the current window without completing it.
   task automatic drive_to(input int stop, input int n, input int sp);
      for (int o = g_off; o < stop; o++) begin
         bus.fb_i = pulse_at(o, n, sp);
         @(negedge clk);
      end
      bus.fb_i = 1'b0;
      g_off = stop;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int w, sp, nmax, tgt, tol, g, init, n, r;

      // Reset held with enable high and feedback toggling
      bus.en_i         = 1'b1;
      bus.fb_i         = 1'b0;
      bus.win_len_i    = CNT_WIDTH'(100);
      bus.target_i     = CNT_WIDTH'(10);
      bus.tol_i        = '0;
      bus.gain_shift_i = '0;
      bus.ctrl_init_i  = CTRL_WIDTH'(512);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.fb_i = ~bus.fb_i;
      end
      chk("rst.ctrl",   bus.ctrl_o, 0);
      chk("rst.locked", bus.locked_o, 0);
      chk("rst.meas",   bus.meas_o, 0);
      chk("rst.err",    bus.err_o, 0);
      chk("rst.valid",  bus.meas_valid_o, 0);
      chk("rst.sat",    bus.sat_o, 0);
      bus.fb_i = 1'b0;
      bus.en_i = 1'b0;
      arst_ni  = 1'b1;
      @(negedge clk);
      chk("rst.release_ctrl", bus.ctrl_o, 512);

      // Steady lock: 10 edges per 100-cycle window on target
      start_loop(512, 100, 10, 0, 0);
      for (int k = 0; k < 4; k++) run_window(10, 10, 100, "lock");
      chk("lock.fourth", bus.locked_o, 1);

      // Target change mid-window while locked aborts the window
      drive_to(30, 10, 10);
      bus.target_i = CNT_WIDTH'(12);
      m_tgt = 12;
      @(negedge clk);
      model_clear_lock();
      chk("abort.locked", bus.locked_o, 0);
      chk("abort.valid",  bus.meas_valid_o, 0);
      chk("abort.ctrl",   bus.ctrl_o, m_ctrl);
      g_off = 0;
      run_window(10, 10, 100, "post_abort");

      // Enable dropped mid-window
      drive_to(50, 10, 10);
      bus.en_i        = 1'b0;
      bus.ctrl_init_i = CTRL_WIDTH'(300);
      @(negedge clk);
      chk("dis.ctrl",   bus.ctrl_o, 300);
      chk("dis.locked", bus.locked_o, 0);
      chk("dis.valid",  bus.meas_valid_o, 0);

      // Correction with unit gain and with forced minimum step
      start_loop(512, 100, 20, 0, 0);
      run_window(10, 10, 100, "corr_g0");
      chk("corr_g0.lit", bus.ctrl_o, 522);
      start_loop(512, 100, 20, 0, 4);
      run_window(10, 10, 100, "corr_g4");
      chk("corr_g4.lit", bus.ctrl_o, 513);
      run_window(10, 10, 100, "corr_g4b");

      // Clamp high then release, clamp low
      start_loop(1020, 100, 20, 0, 0);
      run_window(10, 10, 100, "sat_hi");
      chk("sat_hi.lit", bus.ctrl_o, 1023);
      chk("sat_hi.flag", bus.sat_o, 1);
      run_window(20, 4, 100, "sat_clear");
      chk("sat_clear.flag", bus.sat_o, 0);
      start_loop(3, 100, 0, 0, 0);
      run_window(10, 10, 100, "sat_lo");
      chk("sat_lo.lit", bus.ctrl_o, 0);

      // Edge counted on the last measurement cycle; zero-length window
      start_loop(512, 100, 9, 0, 0);
      run_window(9, 12, 100, "edge_last");
      start_loop(512, 0, 0, 0, 0);
      run_window(0, 2, 0, "win0");
      run_window(0, 2, 0, "win0b");

      // Lock hysteresis with tolerance 2
      start_loop(512, 100, 13, 2, 0);
      for (int k = 0; k < 4; k++) run_window(13, 4, 100, "hyst_lock");
      run_window(10, 4, 100, "hyst_miss1");
      chk("hyst.keep", bus.locked_o, 1);
      run_window(13, 4, 100, "hyst_back");
      run_window(10, 4, 100, "hyst_miss2");
      run_window(10, 4, 100, "hyst_miss3");
      chk("hyst.drop2", bus.locked_o, 0);
      for (int k = 0; k < 4; k++) run_window(13, 4, 100, "hyst_relock");
      run_window(8, 4, 100, "hyst_big");
      chk("hyst.drop5", bus.locked_o, 0);

      // Asynchronous reset mid-window, then restart from ctrl_init_i
      start_loop(512, 100, 10, 0, 0);
      run_window(10, 10, 100, "pre_rst");
      drive_to(40, 10, 10);
      #2;
      arst_ni = 1'b0;
      #1;
      chk("arst.ctrl",   bus.ctrl_o, 0);
      chk("arst.locked", bus.locked_o, 0);
      chk("arst.meas",   bus.meas_o, 0);
      chk("arst.err",    bus.err_o, 0);
      chk("arst.valid",  bus.meas_valid_o, 0);
      chk("arst.sat",    bus.sat_o, 0);
      @(negedge clk);
      bus.ctrl_init_i = CTRL_WIDTH'(700);
      arst_ni = 1'b1;
      @(negedge clk);
      chk("arst.reload", bus.ctrl_o, 700);
      m_ctrl = 700;
      model_clear_lock();
      g_off = 0;
      run_window(10, 10, 100, "post_rst");

      // Randomised scenarios
      for (int s = 0; s < 3; s++) begin
         w    = int'($urandom_range(40, 120));
         sp   = int'($urandom_range(2, 5));
         nmax = (w - 6) / sp + 1;
         tgt  = int'($urandom_range(0, nmax));
         tol  = int'($urandom_range(0, 3));
         g    = int'($urandom_range(0, 5));
         init = int'($urandom_range(0, CTRL_MAX));
         start_loop(init, w, tgt, tol, g);
         for (int k = 0; k < 8; k++) begin
            r = int'($urandom_range(0, 6));
            n = tgt + r - 3;
            if (n < 0) n = 0;
            if (n > nmax) n = nmax;
            run_window(n, sp, w, "rand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
